cache_fill_seq: RTL and testbench

CACHE_FILL_SEQ -- requirements
Module: cache_fill_seq

---
 rtl/cache_fill_seq.sv | 176 +++++++++++++++++
 tb/tb_cache_fill_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_seq.sv
// rtl/cache_fill_seq.sv - CPU access sequencer: cache lookup, write-through memory access and line fill
module cache_fill_seq #(
    parameter int TMO_CYCLES = 255
) (
    input  logic        sysclk,
    input  logic        sys_rst,
    input  logic        REQ,
    input  logic        REQ_WR,
    input  logic [15:0] PPN_25_10,
    input  logic [10:0] CA_10_0,
    input  logic [15:0] WDATA,
    input  logic        HIT,
    input  logic        CON,
    input  logic [15:0] CD_HIT,
    output logic        MREQ,
    output logic        MWR,
    output logic [26:0] MADDR,
    output logic [15:0] MWDATA,
    input  logic        MACK,
    input  logic [15:0] MRDATA,
    output logic        CWR,
    output logic [10:0] CWA,
    output logic [15:0] CWD,
    output logic [13:0] CWPN,
    output logic        RDY,
    output logic [15:0] RDATA,
    output logic        BERR,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEMRQ,
        S_FILL,
        S_DONE
    } state_t;

    // Last MEMRQ cycle index before the access is declared timed out.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    state_t      state;
    state_t      state_nx;

    logic        wr_q;
    logic [15:0] ppn_q;
    logic [10:0] ca_q;
    logic [15:0] wdata_q;
    logic        con_q;
    logic        hitcon_q;
    logic [15:0] fill_q;
    logic [15:0] rdata_q;
    logic        berr_q;
    logic [7:0]  tmo_q;

    logic        lookup_hit;
    logic        tmo_expire;

    assign lookup_hit = !wr_q && HIT && CON;
    assign tmo_expire = !MACK && (tmo_q == TMO_LAST);

    always_comb begin
        state_nx = state;
        MREQ     = 1'b0;
        MWR      = 1'b0;
        CWR      = 1'b0;
        RDY      = 1'b0;
        BERR     = 1'b0;
        BUSY     = 1'b1;
        unique case (state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (REQ) begin
                    state_nx = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_nx = lookup_hit ? S_DONE : S_MEMRQ;
            end
            S_MEMRQ: begin
                MREQ = 1'b1;
                MWR  = wr_q;
                if (MACK) begin
                    // Reads fill only when enabled; writes update only lines that hit.
                    if (!wr_q) begin
                        state_nx = con_q ? S_FILL : S_DONE;
                    end else begin
                        state_nx = hitcon_q ? S_FILL : S_DONE;
                    end
                end else if (tmo_expire) begin
                    state_nx = S_DONE;
                end
            end
            S_FILL: begin
                CWR      = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                RDY      = 1'b1;
                BERR     = berr_q;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            wr_q     <= 1'b0;
            ppn_q    <= 16'h0000;
            ca_q     <= 11'h000;
            wdata_q  <= 16'h0000;
            con_q    <= 1'b0;
            hitcon_q <= 1'b0;
            fill_q   <= 16'h0000;
            rdata_q  <= 16'h0000;
            berr_q   <= 1'b0;
            tmo_q    <= 8'h00;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (REQ) begin
                        wr_q     <= REQ_WR;
                        ppn_q    <= PPN_25_10;
                        ca_q     <= CA_10_0;
                        wdata_q  <= WDATA;
                        berr_q   <= 1'b0;
                        hitcon_q <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    con_q    <= CON;
                    hitcon_q <= HIT && CON;
                    tmo_q    <= 8'h00;
                    if (lookup_hit) begin
                        rdata_q <= CD_HIT;
                    end
                end
                S_MEMRQ: begin
                    if (MACK) begin
                        if (!wr_q) begin
                            fill_q <= MRDATA;
                            if (!con_q) begin
                                rdata_q <= MRDATA;
                            end
                        end else begin
                            fill_q <= wdata_q;
                        end
                    end else if (tmo_expire) begin
                        berr_q  <= 1'b1;
                        rdata_q <= 16'hFFFF;
                    end else begin
                        tmo_q <= tmo_q + 8'h01;
                    end
                end
                S_FILL: begin
                    rdata_q <= fill_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign MADDR  = {ppn_q, ca_q};
    assign MWDATA = wdata_q;
    assign CWA    = ca_q;
    assign CWPN   = ppn_q[13:0];
    assign CWD    = fill_q;
    assign RDATA  = rdata_q;

endmodule

// File: tb/tb_cache_fill_seq.sv
// tb/tb_cache_fill_seq.sv - randomized scoreboard bench for cache_fill_seq
module tb_cache_fill_seq;

    localparam int TMO = 4;

    logic        sysclk = 1'b0;
    logic        sys_rst;
    logic        REQ;
    logic        REQ_WR;
    logic [15:0] PPN_25_10;
    logic [10:0] CA_10_0;
    logic [15:0] WDATA;
    logic        HIT;
    logic        CON;
    logic [15:0] CD_HIT;
    logic        MREQ;
    logic        MWR;
    logic [26:0] MADDR;
    logic [15:0] MWDATA;
    logic        MACK;
    logic [15:0] MRDATA;
    logic        CWR;
    logic [10:0] CWA;
    logic [15:0] CWD;
    logic [13:0] CWPN;
    logic        RDY;
    logic [15:0] RDATA;
    logic        BERR;
    logic        BUSY;

    cache_fill_seq #(.TMO_CYCLES(TMO)) dut (
        .sysclk(sysclk), .sys_rst(sys_rst), .REQ(REQ), .REQ_WR(REQ_WR),
        .PPN_25_10(PPN_25_10), .CA_10_0(CA_10_0), .WDATA(WDATA), .HIT(HIT),
        .CON(CON), .CD_HIT(CD_HIT), .MREQ(MREQ), .MWR(MWR), .MADDR(MADDR),
        .MWDATA(MWDATA), .MACK(MACK), .MRDATA(MRDATA), .CWR(CWR), .CWA(CWA),
        .CWD(CWD), .CWPN(CWPN), .RDY(RDY), .RDATA(RDATA), .BERR(BERR), .BUSY(BUSY)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int          req_cyc;
        int          lat;
        logic        berr;
        logic        chk_rdata;
        logic [15:0] rdata;
    } rsp_t;

    typedef struct {
        logic [10:0] cwa;
        logic [13:0] cwpn;
        logic [15:0] cwd;
    } fill_t;

    typedef struct {
        logic [26:0] addr;
        logic        wr;
        logic [15:0] wdata;
        int          len;
    } mem_t;

    rsp_t  rsp_q[$];
    fill_t fill_q[$];
    mem_t  mem_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge sysclk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents RDY, CWR or a new MREQ.
    rsp_t  mr;
    fill_t mf;
    mem_t  mm;
    logic  have_m    = 1'b0;
    logic  mreq_prev = 1'b0;
    int    run       = 0;

    initial begin
        forever begin
            @(posedge sysclk);
            #1;
            chk("berr_only_with_rdy", 32'(BERR & ~RDY), 0);
            if (RDY) begin
                chk("rdy_expected", 32'(rsp_q.size() != 0), 1);
                if (rsp_q.size() != 0) begin
                    mr = rsp_q.pop_front();
                    chk("rdy_latency", 32'(cyc - mr.req_cyc), 32'(mr.lat));
                    chk("berr", 32'(BERR), 32'(mr.berr));
                    if (mr.chk_rdata) chk("rdata", 32'(RDATA), 32'(mr.rdata));
                end
            end
            if (CWR) begin
                chk("cwr_expected", 32'(fill_q.size() != 0), 1);
                if (fill_q.size() != 0) begin
                    mf = fill_q.pop_front();
                    chk("cwa", 32'(CWA), 32'(mf.cwa));
                    chk("cwpn", 32'(CWPN), 32'(mf.cwpn));
                    chk("cwd", 32'(CWD), 32'(mf.cwd));
                end
            end
            if (MREQ && !mreq_prev) begin
                chk("mreq_expected", 32'(mem_q.size() != 0), 1);
                have_m = (mem_q.size() != 0);
                if (have_m) begin
                    mm = mem_q.pop_front();
                    chk("maddr", 32'(MADDR), 32'(mm.addr));
                    chk("mwr", 32'(MWR), 32'(mm.wr));
                    if (mm.wr) chk("mwdata", 32'(MWDATA), 32'(mm.wdata));
                end
                run = 1;
            end else if (MREQ) begin
                run++;
                if (have_m) chk("maddr_stable", 32'(MADDR), 32'(mm.addr));
            end else if (mreq_prev && have_m) begin
                chk("mreq_len", 32'(run), 32'(mm.len));
            end
            mreq_prev = MREQ;
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_mreq"}, 32'(MREQ), 0);
        chk({tag, "_mwr"}, 32'(MWR), 0);
        chk({tag, "_cwr"}, 32'(CWR), 0);
        chk({tag, "_rdy"}, 32'(RDY), 0);
        chk({tag, "_berr"}, 32'(BERR), 0);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_maddr"}, 32'(MADDR), 0);
        chk({tag, "_mwdata"}, 32'(MWDATA), 0);
        chk({tag, "_cwa"}, 32'(CWA), 0);
        chk({tag, "_cwd"}, 32'(CWD), 0);
        chk({tag, "_cwpn"}, 32'(CWPN), 0);
        chk({tag, "_rdata"}, 32'(RDATA), 0);
    endtask

    // One access: the reference outcome is derived from the access kind and memory wait d,
    // pushed to the scoreboard, then the stimulus and memory response are played out.
    task automatic do_access(input logic wr, input logic [15:0] ppn, input logic [10:0] ca,
                             input logic [15:0] wdata, input logic hit, input logic con,
                             input logic [15:0] cdhit, input int d, input logic [15:0] mrdata);
        logic        needs_mem;
        logic        tmo;
        logic        do_fill;
        logic [15:0] fdata;
        int          len;
        int          k;
        rsp_t        r;
        fill_t       f;
        mem_t        m;

        needs_mem = wr || !(hit && con);
        tmo       = needs_mem && (d >= TMO);
        len       = tmo ? TMO : d + 1;
        do_fill   = needs_mem && !tmo && (wr ? (hit && con) : con);
        fdata     = wr ? wdata : mrdata;

        @(negedge sysclk);
        REQ       = 1'b1;
        REQ_WR    = wr;
        PPN_25_10 = ppn;
        CA_10_0   = ca;
        WDATA     = wdata;
        r.req_cyc   = cyc;
        r.berr      = tmo;
        r.chk_rdata = 1'b1;
        if (!needs_mem) begin
            r.lat   = 2;
            r.rdata = cdhit;
        end else begin
            r.lat = 2 + len + (do_fill ? 1 : 0);
            if (tmo)          r.rdata = 16'hFFFF;
            else if (do_fill) r.rdata = fdata;
            else if (!wr)     r.rdata = mrdata;
            else begin
                r.rdata     = 16'h0000;
                r.chk_rdata = 1'b0;
            end
            m.addr  = {ppn, ca};
            m.wr    = wr;
            m.wdata = wdata;
            m.len   = len;
            mem_q.push_back(m);
        end
        rsp_q.push_back(r);
        if (do_fill) begin
            f.cwa  = ca;
            f.cwpn = ppn[13:0];
            f.cwd  = fdata;
            fill_q.push_back(f);
        end

        @(negedge sysclk);
        REQ       = 1'($urandom_range(0, 1));
        REQ_WR    = 1'($urandom_range(0, 1));
        PPN_25_10 = 16'($urandom);
        CA_10_0   = 11'($urandom);
        WDATA     = 16'($urandom);
        HIT       = hit;
        CON       = con;
        CD_HIT    = cdhit;
        MACK      = 1'($urandom_range(0, 1));
        MRDATA    = 16'($urandom);

        if (needs_mem) begin
            for (int i = 0; i < len; i++) begin
                @(negedge sysclk);
                REQ    = 1'($urandom_range(0, 1));
                HIT    = 1'($urandom_range(0, 1));
                CON    = 1'($urandom_range(0, 1));
                MACK   = !tmo && (i == d);
                MRDATA = (!tmo && (i == d)) ? mrdata : 16'($urandom);
            end
        end
        @(negedge sysclk);
        MACK = 1'b0;
        HIT  = 1'($urandom_range(0, 1));
        CON  = 1'($urandom_range(0, 1));
        k = 0;
        while (BUSY && k < 30) begin
            REQ = 1'($urandom_range(0, 1));
            @(negedge sysclk);
            k++;
        end
        REQ = 1'b0;
        chk("access_completes", 32'(BUSY), 0);
    endtask

    initial begin
        sys_rst   = 1'b1;
        REQ       = 1'b1;
        REQ_WR    = 1'b0;
        PPN_25_10 = 16'h0000;
        CA_10_0   = 11'h000;
        WDATA     = 16'h0000;
        HIT       = 1'b0;
        CON       = 1'b0;
        CD_HIT    = 16'h0000;
        MACK      = 1'b0;
        MRDATA    = 16'h0000;
        repeat (3) @(negedge sysclk);
        sys_rst = 1'b0;
        REQ     = 1'b0;
        check_idle("reset");

        do_access(1'b0, 16'h0012, 11'h05A, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 0, 16'h0000);
        do_access(1'b0, 16'h0012, 11'h05A, 16'h0000, 1'b0, 1'b1, 16'h0000, 3, 16'h1234);
        do_access(1'b1, 16'h0012, 11'h05A, 16'hA5A5, 1'b1, 1'b1, 16'h0000, 1, 16'h5555);
        do_access(1'b1, 16'h0012, 11'h05A, 16'hA5A5, 1'b0, 1'b1, 16'h0000, 1, 16'h5555);
        do_access(1'b0, 16'h3456, 11'h7FF, 16'h0000, 1'b0, 1'b1, 16'h0000, 9, 16'h0000);
        do_access(1'b0, 16'hFFFF, 11'h001, 16'h0000, 1'b0, 1'b1, 16'h0000, TMO - 1, 16'hC0DE);
        do_access(1'b0, 16'h00AB, 11'h123, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 16'h7777);
        do_access(1'b0, 16'h00CD, 11'h321, 16'h0000, 1'b1, 1'b0, 16'h1111, 2, 16'h8888);
        do_access(1'b1, 16'h4321, 11'h0F0, 16'h9999, 1'b1, 1'b1, 16'h0000, 7, 16'h0000);

        // Reset during MEMRQ followed by a late MACK: access is abandoned.
        @(negedge sysclk);
        REQ       = 1'b1;
        REQ_WR    = 1'b0;
        PPN_25_10 = 16'h0777;
        CA_10_0   = 11'h444;
        begin
            mem_t m;
            m.addr  = {16'h0777, 11'h444};
            m.wr    = 1'b0;
            m.wdata = 16'h0000;
            m.len   = 1;
            mem_q.push_back(m);
        end
        @(negedge sysclk);
        REQ = 1'b0;
        HIT = 1'b0;
        CON = 1'b1;
        @(negedge sysclk);
        chk("mreq_before_reset", 32'(MREQ), 1);
        sys_rst = 1'b1;
        REQ     = 1'b1;
        @(negedge sysclk);
        sys_rst = 1'b0;
        REQ     = 1'b0;
        MACK    = 1'b1;
        MRDATA  = 16'hDEAD;
        check_idle("midrst");
        @(negedge sysclk);
        MACK = 1'b0;
        check_idle("late_mack");
        repeat (3) @(negedge sysclk);
        do_access(1'b0, 16'h0012, 11'h05A, 16'h0000, 1'b0, 1'b1, 16'h0000, 1, 16'h4242);

        for (int n = 0; n < 80; n++) begin
            do_access(1'($urandom_range(0, 1)), 16'($urandom), 11'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 16'($urandom),
                      ($urandom_range(0, 7) == 0) ? TMO + 1 : int'($urandom_range(0, TMO - 1)),
                      16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge sysclk);
        end

        repeat (5) @(negedge sysclk);
        chk("rsp_q_drained", 32'(rsp_q.size()), 0);
        chk("fill_q_drained", 32'(fill_q.size()), 0);
        chk("mem_q_drained", 32'(mem_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
